// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and defaults for the FIFO burst reader: FSM state encoding,
// default widths and the read latency of the team's synchronous FIFO.
package fifo_burst_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int DATA_WIDTH_DEF  = 8;
   localparam int CNT_WIDTH_DEF   = 5;
   localparam int FIFO_RD_LATENCY = 1;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus output stream of the burst reader, bundled with a
// master view (the reader) and a slave view (FIFO and downstream sink).
interface fifo_burst_reader_if
   import fifo_burst_reader_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int CNT_WIDTH  = CNT_WIDTH_DEF
);
   logic                  fifo_empty;
   logic [CNT_WIDTH-1:0]  fifo_count;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  fifo_rd_en;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;
   logic                  busy;

   modport master (
      input  fifo_empty, fifo_count, fifo_data, m_ready,
      output fifo_rd_en, m_valid, m_data, m_last, busy
   );

   modport slave (
      output fifo_empty, fifo_count, fifo_data, m_ready,
      input  fifo_rd_en, m_valid, m_data, m_last, busy
   );
endinterface

// File: rtl/fifo_burst_reader_skid_buf.sv
// Two-entry {last, data} skid buffer on the reader's output side.
// level_after_pop is occupancy net of this cycle's transfer, used as read credit.
module burst_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         capture,
   input  logic [W-1:0] capture_data,
   input  logic         capture_last,
   output logic         valid,
   input  logic         ready,
   output logic [W-1:0] data,
   output logic         last,
   output logic [1:0]   level_after_pop
);
   logic [W:0] entry_r [2];
   logic       wr_ptr_r;
   logic       rd_ptr_r;
   logic [1:0] level_r;
   logic       pop_s;

   assign valid           = (level_r != 2'd0);
   assign pop_s           = valid && ready;
   assign data            = entry_r[rd_ptr_r][W-1:0];
   assign last            = entry_r[rd_ptr_r][W];
   assign level_after_pop = level_r - {1'b0, pop_s};

   // Entry storage, read/write pointers and occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         entry_r[0] <= '0;
         entry_r[1] <= '0;
         wr_ptr_r   <= 1'b0;
         rd_ptr_r   <= 1'b0;
         level_r    <= 2'd0;
      end else begin
         if (capture) begin
            entry_r[wr_ptr_r] <= {capture_last, capture_data};
            wr_ptr_r          <= ~wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         level_r <= level_r + {1'b0, capture} - {1'b0, pop_s};
      end
   end
endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side controller for the synchronous FIFO: drains it in bursts of up to
// BURST_LEN words onto a valid/ready stream, flushing partial fills after TIMEOUT.
module fifo_burst_reader
   import fifo_burst_reader_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
   parameter int BURST_LEN  = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   fifo_burst_reader_if.master  bus
);
   localparam logic [CNT_WIDTH-1:0] BURST_LEN_C = CNT_WIDTH'(BURST_LEN);
   localparam logic [CNT_WIDTH-1:0] TIMEOUT_C   = CNT_WIDTH'(TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] ONE_C       = CNT_WIDTH'(1);

   state_t                     state_r;
   logic [CNT_WIDTH-1:0]       rd_left_r;
   logic [CNT_WIDTH-1:0]       words_left_r;
   logic [CNT_WIDTH-1:0]       timer_r;
   logic [FIFO_RD_LATENCY-1:0] rd_pipe_r;
   logic [FIFO_RD_LATENCY-1:0] last_pipe_r;
   logic                       start_s;
   logic                       rd_en_s;
   logic                       xfer_s;
   logic                       inflight_s;
   logic [CNT_WIDTH-1:0]       len_s;
   logic [1:0]                 level_after_s;

   assign inflight_s     = rd_pipe_r[FIFO_RD_LATENCY-1];
   assign xfer_s         = bus.m_valid && bus.m_ready;
   assign bus.fifo_rd_en = rd_en_s;
   assign bus.busy       = (state_r != IDLE);

   // Burst start decision, burst length and FIFO read strobe
   always_comb begin
      start_s = 1'b0;
      if (state_r != IDLE) begin
         start_s = 1'b0;
      end else if (bus.fifo_count >= BURST_LEN_C) begin
         start_s = 1'b1;
      end else begin
         start_s = (bus.fifo_count != '0) && (timer_r == TIMEOUT_C);
      end
      len_s = (bus.fifo_count >= BURST_LEN_C) ? BURST_LEN_C : bus.fifo_count;
      // A word leaving the buffer this cycle frees its slot for a new read.
      rd_en_s = (state_r == BURST) && (rd_left_r != '0) && !bus.fifo_empty &&
                (({1'b0, level_after_s} + {2'b00, inflight_s}) < 3'd2);
   end

   // FSM, idle timer, burst counters and read-latency pipeline
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         rd_left_r    <= '0;
         words_left_r <= '0;
         timer_r      <= '0;
         rd_pipe_r    <= '0;
         last_pipe_r  <= '0;
      end else begin
         rd_pipe_r[0]   <= rd_en_s;
         last_pipe_r[0] <= rd_en_s && (rd_left_r == ONE_C);
         case (state_r)
            IDLE: begin
               if (start_s) begin
                  state_r      <= BURST;
                  rd_left_r    <= len_s;
                  words_left_r <= len_s;
                  timer_r      <= '0;
               end else if (bus.fifo_count == '0) begin
                  timer_r <= '0;
               end else if (timer_r != TIMEOUT_C) begin
                  timer_r <= timer_r + ONE_C;
               end
            end
            BURST: begin
               if (rd_en_s) begin
                  rd_left_r <= rd_left_r - ONE_C;
                  if (rd_left_r == ONE_C) begin
                     state_r <= DRAIN;
                  end
               end
               if (xfer_s) begin
                  words_left_r <= words_left_r - ONE_C;
               end
            end
            DRAIN: begin
               if (xfer_s) begin
                  words_left_r <= words_left_r - ONE_C;
                  if (words_left_r == ONE_C) begin
                     state_r <= IDLE;
                  end
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   burst_skid_buf #(
      .W (DATA_WIDTH)
   ) u_skid (
      .clk             (clk),
      .reset           (reset),
      .capture         (inflight_s),
      .capture_data    (bus.fifo_data),
      .capture_last    (last_pipe_r[FIFO_RD_LATENCY-1]),
      .valid           (bus.m_valid),
      .ready           (bus.m_ready),
      .data            (bus.m_data),
      .last            (bus.m_last),
      .level_after_pop (level_after_s)
   );
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench: the bench plays the FIFO and the sink, and a burst-level
// model predicts busy, word order, m_last and first-word latency every cycle.
`timescale 1ns/1ps
module tb_fifo_burst_reader;
   import fifo_burst_reader_pkg::*;

   localparam int DW = 8;
   localparam int CW = 5;
   localparam int BL = 4;
   localparam int TO = 15;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fifo_burst_reader_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

   fifo_burst_reader #(
      .DATA_WIDTH (DW),
      .CNT_WIDTH  (CW),
      .BURST_LEN  (BL),
      .TIMEOUT    (TO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] wr_pending[$];
   bit            pop_pending;
   bit            next_ready;

   bit mdl_idle;
   int mdl_timer, mdl_len, mdl_sent, mdl_reads, mdl_age;

   bit            prev_stall;
   logic [DW-1:0] prev_data;
   logic          prev_last;
   bit            xfer_d1, xfer_d2;

   int            log_cyc[$];
   logic [DW-1:0] log_data[$];
   bit            log_last[$];
   int            first_rd_cyc;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Burst-level reference: decides when bursts start and how long they are from the
   // FIFO occupancy alone, then scores every transfer against write order.
   task automatic model_cycle();
      bit xfer;
      int cnt;
      cnt  = fifo_q.size();
      xfer = bus.m_valid && bus.m_ready;
      chk("busy", int'(bus.busy), int'(!mdl_idle));
      if (bus.fifo_empty) chk("rd_en_while_empty", int'(bus.fifo_rd_en), 0);
      chk("outstanding_le_2", int'((mdl_reads - mdl_sent) <= 2), 1);
      if (prev_stall) begin
         chk("hold_valid", int'(bus.m_valid), 1);
         chk("hold_data", int'(bus.m_data), int'(prev_data));
         chk("hold_last", int'(bus.m_last), int'(prev_last));
      end
      if (mdl_idle) begin
         chk("idle_rd_en", int'(bus.fifo_rd_en), 0);
         chk("idle_valid", int'(bus.m_valid), 0);
         if (cnt >= BL || (cnt != 0 && mdl_timer == TO)) begin
            mdl_idle  = 1'b0;
            mdl_len   = (cnt < BL) ? cnt : BL;
            mdl_sent  = 0;
            mdl_reads = 0;
            mdl_age   = 0;
            mdl_timer = 0;
         end else if (cnt == 0) begin
            mdl_timer = 0;
         end else if (mdl_timer < TO) begin
            mdl_timer++;
         end
      end else begin
         mdl_age++;
         if (mdl_sent == 0) chk("first_valid_latency", int'(bus.m_valid), int'(mdl_age >= 3));
         if (xfer_d1 && xfer_d2 && mdl_sent < mdl_len) chk("throughput", int'(bus.m_valid), 1);
         if (bus.fifo_rd_en) begin
            chk("reads_within_len", int'(mdl_reads < mdl_len), 1);
            mdl_reads++;
         end
         if (xfer) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", int'(bus.m_data), -1);
            end else begin
               chk("m_data", int'(bus.m_data), int'(exp_q.pop_front()));
            end
            chk("m_last", int'(bus.m_last), int'(mdl_sent == mdl_len - 1));
            log_cyc.push_back(cyc);
            log_data.push_back(bus.m_data);
            log_last.push_back(bus.m_last);
            mdl_sent++;
            if (mdl_sent == mdl_len) mdl_idle = 1'b1;
         end
      end
      if (bus.fifo_rd_en && first_rd_cyc < 0) first_rd_cyc = cyc;
      pop_pending = bus.fifo_rd_en && !bus.fifo_empty;
      prev_stall  = bus.m_valid && !bus.m_ready;
      prev_data   = bus.m_data;
      prev_last   = bus.m_last;
      xfer_d2     = xfer_d1;
      xfer_d1     = xfer;
   endtask

   task automatic apply_inputs();
      logic [DW-1:0] w;
      if (pop_pending) begin
         bus.fifo_data = fifo_q.pop_front();
         pop_pending   = 1'b0;
      end
      while (wr_pending.size() > 0) begin
         w = wr_pending.pop_front();
         fifo_q.push_back(w);
         exp_q.push_back(w);
      end
      bus.fifo_count = CW'(fifo_q.size());
      bus.fifo_empty = (fifo_q.size() == 0);
      bus.m_ready    = next_ready;
   endtask

   task automatic tick();
      @(negedge clk);
      if (!reset) model_cycle();
      @(posedge clk);
      #1;
      cyc++;
      apply_inputs();
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      #1;
      chk("rst_m_valid", int'(bus.m_valid), 0);
      chk("rst_rd_en", int'(bus.fifo_rd_en), 0);
      chk("rst_busy", int'(bus.busy), 0);
      repeat (mdl_reads - mdl_sent) void'(exp_q.pop_front());
      mdl_idle = 1'b1; mdl_timer = 0; mdl_len = 0; mdl_sent = 0; mdl_reads = 0;
      prev_stall = 1'b0; xfer_d1 = 1'b0; xfer_d2 = 1'b0; pop_pending = 1'b0;
      repeat (cycles) tick();
      reset = 1'b0;
   endtask

   task automatic wait_done(input int n_words, input int budget, input string name);
      int k;
      k = 0;
      while (!(log_data.size() >= n_words && mdl_idle) && k < budget) begin
         tick();
         k++;
      end
      chk(name, int'(log_data.size() >= n_words && mdl_idle), 1);
   endtask

   task automatic clear_log();
      log_cyc.delete();
      log_data.delete();
      log_last.delete();
      first_rd_cyc = -1;
   endtask

   task automatic check_stream(input string name, input int base, input int n, input int last_mask);
      chk({name, "_count"}, log_data.size(), n);
      for (int i = 0; i < n && i < log_data.size(); i++) begin
         chk({name, "_data"}, int'(log_data[i]), base + i);
         chk({name, "_last"}, int'(log_last[i]), (last_mask >> i) & 1);
      end
   endtask

   initial begin
      int wr_cyc;
      int wp;
      reset = 1'b1;
      bus.fifo_empty = 1'b1;
      bus.fifo_count = '0;
      bus.fifo_data  = '0;
      bus.m_ready    = 1'b0;
      next_ready = 1'b0; pop_pending = 1'b0;
      mdl_idle = 1'b1; mdl_timer = 0; mdl_len = 0; mdl_sent = 0; mdl_reads = 0; mdl_age = 0;
      prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; xfer_d1 = 1'b0; xfer_d2 = 1'b0;
      first_rd_cyc = -1;
      #1;
      chk("reset_m_valid", int'(bus.m_valid), 0);
      chk("reset_m_data", int'(bus.m_data), 0);
      chk("reset_m_last", int'(bus.m_last), 0);
      chk("reset_rd_en", int'(bus.fifo_rd_en), 0);
      chk("reset_busy", int'(bus.busy), 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Four words, sink always ready: one contiguous burst
      next_ready = 1'b1;
      tick();
      clear_log();
      for (int i = 0; i < 4; i++) wr_pending.push_back(DW'(8'hA1 + i));
      tick();
      wr_cyc = cyc;
      wait_done(4, 40, "t1_timeout");
      check_stream("t1", 8'hA1, 4, 4'b1000);
      if (log_cyc.size() == 4) begin
         chk("t1_first_latency", log_cyc[0] - wr_cyc, 3);
         chk("t1_contiguous", log_cyc[3] - log_cyc[0], 3);
      end
      chk("t1_busy_after", int'(bus.busy), 0);

      // Nine words: 4 + 4, then a timed-out single word
      repeat (3) tick();
      clear_log();
      for (int i = 0; i < 9; i++) wr_pending.push_back(DW'(8'h10 + i));
      tick();
      wait_done(9, 200, "t2_timeout");
      check_stream("t2", 8'h10, 9, 9'b1_1000_1000);
      if (log_cyc.size() == 9) chk("t2_last_gap", log_cyc[8] - log_cyc[7], TO + 4);

      // Two words only: timeout-driven short burst
      repeat (3) tick();
      clear_log();
      wr_pending.push_back(8'h31);
      wr_pending.push_back(8'h32);
      tick();
      wr_cyc = cyc;
      wait_done(2, 60, "t3_timeout");
      chk("t3_first_read", first_rd_cyc - wr_cyc, TO + 1);
      check_stream("t3", 8'h31, 2, 2'b10);

      // Backpressure for five cycles mid-burst
      repeat (3) tick();
      clear_log();
      for (int i = 0; i < 8; i++) wr_pending.push_back(DW'(8'h40 + i));
      tick();
      for (int k = 0; k < 40 && log_data.size() < 2; k++) tick();
      next_ready = 1'b0;
      repeat (5) tick();
      next_ready = 1'b1;
      wait_done(8, 100, "t4_timeout");
      check_stream("t4", 8'h40, 8, 8'b1000_1000);

      // Reset with one word buffered, then the rest of the FIFO drains in order
      repeat (3) tick();
      clear_log();
      next_ready = 1'b0;
      for (int i = 0; i < 6; i++) wr_pending.push_back(DW'(8'h60 + i));
      tick();
      for (int k = 0; k < 20 && !bus.m_valid; k++) tick();
      chk("t5_valid_before_reset", int'(bus.m_valid), 1);
      do_reset(2);
      chk("t5_idle_after_release", int'(bus.busy), 0);
      next_ready = 1'b1;
      wait_done(4, 60, "t5_timeout");
      check_stream("t5", 8'h62, 4, 4'b1000);

      // Randomized traffic, backpressure and occasional resets
      wp = 40;
      for (int c = 0; c < 4000; c++) begin
         if (c % 200 == 0) wp = $urandom_range(0, 60);
         if ($urandom_range(0, 99) < wp && fifo_q.size() + wr_pending.size() < 28)
            wr_pending.push_back(DW'($urandom_range(0, 255)));
         next_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 499) == 0) do_reset($urandom_range(1, 3));
         else tick();
      end

      next_ready = 1'b1;
      for (int k = 0; k < 300 && !(exp_q.size() == 0 && mdl_idle && fifo_q.size() == 0); k++) tick();
      chk("final_drain", int'(exp_q.size() == 0 && mdl_idle && fifo_q.size() == 0), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
